seq_detector_moore_param: RTL and testbench
===========================================

Name: seq_detector_moore_param

Overview:
Parametrised Moore-type serial sequence detector, successor to the fixed-pattern Moore detector.
- Pattern length, pattern value and overlap mode are set at elaboration.
- Adds input enable, synchronous clear and an optional match counter.
- Sits on a 1-bit serial stream sampled on `clk`. Its registered match flag feeds downstream control or LED logic.

Parameters:
- `PAT_LEN`, 4: pattern length in bits. Legal range 2..16.
- `PATTERN`, 4'b1011: target sequence, `PAT_LEN` bits wide. `PATTERN[PAT_LEN-1]` is the first bit received.
- `OVERLAP`, 1: 1 means overlapping matches are detected; 0 means the detector restarts after each match.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `x`  input  1  serial data bit; sampled when `en`=1.
- `en`  input  1  sample enable; when 0, state holds.
- `clr`  input  1  synchronous clear to the idle state; has priority over `en`.
- `Z`  output  1  Moore match flag; 1 while the FSM is in the MATCH state.
- `state_o`  output  `$clog2(PAT_LEN+1)`  current state index, for debug.
- `match_cnt`  output  `CNT_W`  number of matches seen; only live with the optional feature.

Behaviour:
- **State encoding.** State index s = 0..`PAT_LEN`. s = number of pattern bits currently matched. s = `PAT_LEN` is MATCH.
- **Reset.** `rst_n`=0 forces, immediately and asynchronously: s=0, `Z`=0, `state_o`=0, `match_cnt`=0. Reset mid-pattern discards partial progress. Release is synchronous to the next rising edge.
- **Moore output.** `Z` = (s == `PAT_LEN`), decoded from the state register only, with no combinational path from `x`. When the edge sampling the final pattern bit moves the FSM to MATCH, `Z` rises after that edge and stays high for exactly one cycle per enabled sample. With `en`=0 it holds until the next enabled sample.
- **Transitions for s < `PAT_LEN`** (`en`=1, `clr`=0):
  - If `x` == `PATTERN[PAT_LEN-1-s]`, then s ← s+1.
  - Otherwise s ← the length of the longest proper suffix of (matched prefix followed by `x`) that is also a prefix of `PATTERN`. This is the KMP failure transition.
  - The full next-state table is computed at elaboration with a constant function or generate loop. No runtime search.
- **Transition from MATCH with `OVERLAP`=1.** s ← δ(f(`PAT_LEN`), `x`), where f is the failure length of the full pattern and δ is the rule above.
- **Transition from MATCH with `OVERLAP`=0.** s ← δ(0, `x`): the detector restarts as if idle, and bits of the completed match are not reused.
- **Enable low.** `en`=0: s, `Z` and `match_cnt` hold and `x` is ignored.
- **Clear.** `clr`=1 at an edge: s ← 0 regardless of `en` and `x`. `match_cnt` is also cleared.
- **Single-bit patterns.** Not supported; `PAT_LEN` < 2 is an elaboration error, raised through a generate-time check.
- **Back-to-back matches.** Consecutive matches are legal. `Z` stays high on consecutive enabled cycles if the pattern permits, for example `PATTERN`=2'b11 with `OVERLAP`=1 on an all-ones stream.

Optional Feature:
- Macro: `SEQDET_COUNT_EN`.
- **Defined.** `match_cnt` increments by 1 on every enabled edge whose next state is MATCH, saturating at 2^`CNT_W`−1 with no wrap. It is cleared by reset or `clr`. When `clr` and a match occur at the same edge, the clear wins and the count is 0.
- **Not defined.** `match_cnt` is tied to 0 and no counter flops are inferred. `Z` and FSM behaviour are unchanged.

Test Plan:
1. **Overlap mode.** Defaults (1011, `OVERLAP`=1), `en`=1, `x` stream 1,0,1,1,0,1,1 → `Z`=1 in the cycle after bit 4 and after bit 7, 0 elsewhere. `match_cnt`=2 with the macro defined.
2. **Non-overlap mode.** Same stream with `OVERLAP`=0 → `Z`=1 only after bit 4; `state_o` after bit 7 is 1. `match_cnt`=1.
3. **Failure transition.** Stream 1,0,1,0,1,1 (defaults) → after bit 4 `state_o`=2, not 0. `Z`=1 after bit 6.
4. **Enable gating.** Feed 1,0,1 then hold `en`=0 for 5 cycles while toggling `x`, then `en`=1 with `x`=1 → `state_o` stays 3 during the hold. `Z`=1 after the final bit.
5. **Clear and reset.** Assert `clr` with `x`=1 while `state_o`=3 → `state_o`=0 next cycle and no match. Separately, pull `rst_n` low mid-cycle while in MATCH → `Z`=0 and `match_cnt`=0 immediately, without waiting for a clock edge.
6. **Counter saturation.** `CNT_W`=2, `PATTERN`=2'b11, `OVERLAP`=1, all-ones stream for 8 enabled cycles (macro defined) → `match_cnt` climbs 1,2,3 then holds at 3. `Z` stays high continuously from the second edge.

Source files
------------

// File: rtl/seq_detector_moore_param_if.sv
// Serial-stream bundle for seq_detector_moore_param: sample bit, enable, clear, match flag, debug state, match count.
interface seq_detector_moore_param_if #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
);
   localparam int ST_W = $clog2(PAT_LEN + 1);

   logic             x;
   logic             en;
   logic             clr;
   logic             Z;
   logic [ST_W-1:0]  state_o;
   logic [CNT_W-1:0] match_cnt;

   modport master (output x, en, clr, input Z, state_o, match_cnt);
   modport slave  (input x, en, clr, output Z, state_o, match_cnt);
endinterface

// File: rtl/seq_detector_moore_param.sv
// Parametrised Moore sequence detector with a KMP next-state table built at elaboration; Z registered, one cycle after the last bit.
// Optional saturating match counter enabled by macro SEQDET_COUNT_EN (counter tied to 0 otherwise).
module seq_detector_moore_param #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic clk,
   input  logic rst_n,
   seq_detector_moore_param_if.slave bus
);
   localparam int ST_W = $clog2(PAT_LEN + 1);
   typedef logic [ST_W-1:0] state_t;
   localparam state_t S_IDLE  = '0;
   localparam state_t S_MATCH = state_t'(PAT_LEN);

   if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
      $error("seq_detector_moore_param: PAT_LEN must be in 2..16");
   end

   // Longest prefix of PATTERN that is a suffix of (first s pattern bits, then b).
   function automatic int delta(input int s, input logic b);
      int   kmax;
      int   j;
      logic ok;
      logic sb;
      delta = 0;
      kmax  = (s + 1 > PAT_LEN) ? PAT_LEN : s + 1;
      for (int k = 1; k <= kmax; k++) begin
         ok = 1'b1;
         for (int i = 0; i < k; i++) begin
            j  = s + 1 - k + i;
            sb = (j < s) ? PATTERN[PAT_LEN-1-j] : b;
            if (sb != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
         end
         if (ok) delta = k;
      end
   endfunction

   function automatic int fail_len();
      logic ok;
      fail_len = 0;
      for (int k = 1; k < PAT_LEN; k++) begin
         ok = 1'b1;
         for (int i = 0; i < k; i++)
            if (PATTERN[k-1-i] != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
         if (ok) fail_len = k;
      end
   endfunction

   localparam int F_FULL = fail_len();

   state_t w_nxt0 [0:PAT_LEN];
   state_t w_nxt1 [0:PAT_LEN];

   // The MATCH row reuses the row of the state it falls back to.
   for (genvar gs = 0; gs <= PAT_LEN; gs++) begin : g_tbl
      localparam int BASE = (gs == PAT_LEN) ? (OVERLAP ? F_FULL : 0) : gs;
      localparam int N0   = delta(BASE, 1'b0);
      localparam int N1   = delta(BASE, 1'b1);
      assign w_nxt0[gs] = state_t'(N0);
      assign w_nxt1[gs] = state_t'(N1);
   end

   state_t r_state;
   state_t w_state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.clr)
         w_state_nxt = S_IDLE;
      else if (bus.en)
         w_state_nxt = bus.x ? w_nxt1[r_state] : w_nxt0[r_state];
   end

   assign bus.Z       = (r_state == S_MATCH);
   assign bus.state_o = r_state;

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (bus.clr)
         r_cnt <= '0;
      else if (bus.en && w_state_nxt == S_MATCH && r_cnt != {CNT_W{1'b1}})
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign bus.match_cnt = r_cnt;
`else
   assign bus.match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detector_moore_param.sv
// Directed bench: three detector instances (1011 overlap, 1011 non-overlap, 11 with 2-bit counter) share one input stream.
module tb_seq_detector_moore_param;
`ifdef SEQDET_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic x, en, clr;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   seq_detector_moore_param_if #(.PAT_LEN(4), .CNT_W(8)) if_ov ();
   seq_detector_moore_param_if #(.PAT_LEN(4), .CNT_W(8)) if_nov ();
   seq_detector_moore_param_if #(.PAT_LEN(2), .CNT_W(2)) if_sat ();

   assign if_ov.x  = x; assign if_ov.en  = en; assign if_ov.clr  = clr;
   assign if_nov.x = x; assign if_nov.en = en; assign if_nov.clr = clr;
   assign if_sat.x = x; assign if_sat.en = en; assign if_sat.clr = clr;

   seq_detector_moore_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
      .clk(clk), .rst_n(rst_n), .bus(if_ov.slave));
   seq_detector_moore_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
      .clk(clk), .rst_n(rst_n), .bus(if_nov.slave));
   seq_detector_moore_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .bus(if_sat.slave));

   task automatic step(input logic bx, input logic ben, input logic bclr);
      x = bx; en = ben; clr = bclr;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; x = 1'b1; en = 1'b1; clr = 1'b0;
      #12;
      n_checks += 3;
      if (if_ov.state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", if_ov.state_o); end
      if (if_ov.Z !== 1'b0 || if_nov.Z !== 1'b0 || if_sat.Z !== 1'b0) begin
         n_fail++; $display("FAIL reset_z got %b%b%b exp 000", if_ov.Z, if_nov.Z, if_sat.Z);
      end
      if (if_ov.match_cnt !== 8'd0 || if_sat.match_cnt !== 2'd0) begin
         n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0", if_ov.match_cnt, if_sat.match_cnt);
      end
      en = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_overlap();
      logic [6:0] stream = 7'b1011011;
      int exp_s [7] = '{1, 2, 3, 4, 2, 3, 4};
      int exp_c = 0;
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(stream[6-i], 1'b1, 1'b0);
         if (exp_s[i] == 4) exp_c++;
         n_checks += 2;
         if (if_ov.state_o !== 3'(exp_s[i]) || if_ov.Z !== (exp_s[i] == 4)) begin
            n_fail++; $display("FAIL ov_bit%0d got s=%0d z=%b exp s=%0d", i + 1, if_ov.state_o, if_ov.Z, exp_s[i]);
         end
         if (if_ov.match_cnt !== 8'(CNT_ON ? exp_c : 0)) begin
            n_fail++; $display("FAIL ov_cnt%0d got %0d exp %0d", i + 1, if_ov.match_cnt, CNT_ON ? exp_c : 0);
         end
      end
   endtask

   task automatic test_non_overlap();
      logic [6:0] stream = 7'b1011011;
      int exp_s [7] = '{1, 2, 3, 4, 0, 1, 1};
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(stream[6-i], 1'b1, 1'b0);
         n_checks++;
         if (if_nov.state_o !== 3'(exp_s[i]) || if_nov.Z !== (exp_s[i] == 4)) begin
            n_fail++; $display("FAIL nov_bit%0d got s=%0d z=%b exp s=%0d", i + 1, if_nov.state_o, if_nov.Z, exp_s[i]);
         end
      end
      n_checks++;
      if (if_nov.match_cnt !== 8'(CNT_ON ? 1 : 0)) begin
         n_fail++; $display("FAIL nov_cnt got %0d exp %0d", if_nov.match_cnt, CNT_ON ? 1 : 0);
      end
   endtask

   task automatic test_failure_transition();
      logic [5:0] stream = 6'b101011;
      int exp_s [6] = '{1, 2, 3, 2, 3, 4};
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(stream[5-i], 1'b1, 1'b0);
         n_checks++;
         if (if_ov.state_o !== 3'(exp_s[i]) || if_ov.Z !== (exp_s[i] == 4)) begin
            n_fail++; $display("FAIL kmp_bit%0d got s=%0d z=%b exp s=%0d", i + 1, if_ov.state_o, if_ov.Z, exp_s[i]);
         end
      end
   endtask

   task automatic test_enable();
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(logic'(i % 2), 1'b0, 1'b0);
         n_checks++;
         if (if_ov.state_o !== 3'd3 || if_ov.Z !== 1'b0) begin
            n_fail++; $display("FAIL en_hold%0d got s=%0d z=%b exp s=3 z=0", i, if_ov.state_o, if_ov.Z);
         end
      end
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (if_ov.state_o !== 3'd4 || if_ov.Z !== 1'b1) begin
         n_fail++; $display("FAIL en_resume got s=%0d z=%b exp s=4 z=1", if_ov.state_o, if_ov.Z);
      end
   endtask

   task automatic test_clear_reset();
      logic [5:0] stream = 6'b101101;
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(stream[5-i], 1'b1, 1'b0);
      n_checks++;
      if (if_ov.state_o !== 3'd3 || if_ov.match_cnt !== 8'(CNT_ON ? 1 : 0)) begin
         n_fail++; $display("FAIL clr_pre got s=%0d cnt=%0d exp s=3 cnt=%0d", if_ov.state_o, if_ov.match_cnt, CNT_ON ? 1 : 0);
      end
      step(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (if_ov.state_o !== 3'd0 || if_ov.Z !== 1'b0 || if_ov.match_cnt !== 8'd0) begin
         n_fail++; $display("FAIL clr_wins got s=%0d z=%b cnt=%0d exp 0/0/0", if_ov.state_o, if_ov.Z, if_ov.match_cnt);
      end
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (if_ov.state_o !== 3'd0) begin
         n_fail++; $display("FAIL clr_no_en got s=%0d exp 0", if_ov.state_o);
      end
      step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (if_ov.Z !== 1'b1 || if_ov.match_cnt !== 8'(CNT_ON ? 1 : 0)) begin
         n_fail++; $display("FAIL rst_pre got z=%b cnt=%0d exp z=1", if_ov.Z, if_ov.match_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (if_ov.Z !== 1'b0 || if_ov.state_o !== 3'd0 || if_ov.match_cnt !== 8'd0) begin
         n_fail++; $display("FAIL rst_async got s=%0d z=%b cnt=%0d exp 0/0/0", if_ov.state_o, if_ov.Z, if_ov.match_cnt);
      end
      #2 rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back_saturation();
      int exp_c [8] = '{0, 1, 2, 3, 3, 3, 3, 3};
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0);
         n_checks += 2;
         if (if_sat.Z !== (i >= 1) || if_sat.state_o !== 2'((i >= 1) ? 2 : 1)) begin
            n_fail++; $display("FAIL sat_z%0d got z=%b s=%0d exp z=%b", i + 1, if_sat.Z, if_sat.state_o, i >= 1);
         end
         if (if_sat.match_cnt !== 2'(CNT_ON ? exp_c[i] : 0)) begin
            n_fail++; $display("FAIL sat_cnt%0d got %0d exp %0d", i + 1, if_sat.match_cnt, CNT_ON ? exp_c[i] : 0);
         end
      end
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (if_sat.Z !== 1'b1 || if_sat.match_cnt !== 2'(CNT_ON ? 3 : 0)) begin
         n_fail++; $display("FAIL sat_en_hold got z=%b cnt=%0d exp z=1", if_sat.Z, if_sat.match_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_non_overlap();
      test_failure_transition();
      test_enable();
      test_clear_reset();
      test_back_to_back_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
